// File: rtl/fifo_stream_out_if.sv
// FIFO read port plus framed valid/ready stream. The drain stage is the master
// of the stream and drives the FIFO pop strobe.
interface fifo_stream_out_if #(
    parameter int W = 8
);
    logic         fifo_empty;
    logic [W-1:0] fifo_rd_data;
    logic         fifo_rd_en;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         m_ready;
    logic         pkt_done;

    modport master (
        input  fifo_empty, fifo_rd_data, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last, pkt_done
    );

    modport slave (
        output fifo_empty, fifo_rd_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last, pkt_done
    );
endinterface

// File: rtl/fifo_stream_out.sv
// Drains a sync FIFO into a registered valid/ready stream through a 2-entry
// skid buffer and frames the beats into BURST-long packets.
module fifo_stream_out #(
    parameter int W     = 8,
    parameter int BURST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    fifo_stream_out_if.master bus
);
    localparam int            BW        = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

    logic [1:0]    cnt, cnt_n;
    logic [W-1:0]  buf0, buf0_n, buf1, buf1_n;
    logic [BW-1:0] beat, beat_n;
    logic          valid, last, done;
    logic          ld, acc;

    // Pop only on free space as seen at the start of the cycle, so the FIFO
    // strobe never depends combinationally on m_ready.
    assign ld  = reset_n & ~bus.fifo_empty & (cnt != 2'd2);
    assign acc = valid & bus.m_ready;

    always_comb begin
        cnt_n  = cnt;
        buf0_n = buf0;
        buf1_n = buf1;
        case (cnt)
            2'd0: begin
                if (ld) begin
                    buf0_n = bus.fifo_rd_data;
                    cnt_n  = 2'd1;
                end
            end
            2'd1: begin
                if (ld && !acc) begin
                    buf1_n = bus.fifo_rd_data;
                    cnt_n  = 2'd2;
                end else if (acc && !ld) begin
                    cnt_n  = 2'd0;
                end else if (ld && acc) begin
                    buf0_n = bus.fifo_rd_data;
                end
            end
            default: begin
                if (acc) begin
                    buf0_n = buf1;
                    cnt_n  = 2'd1;
                end
            end
        endcase
    end

    always_comb begin
        beat_n = beat;
        if (acc) beat_n = (beat == LAST_BEAT) ? '0 : beat + BW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            buf0  <= '0;
            buf1  <= '0;
            beat  <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
            done  <= 1'b0;
        end else begin
            cnt   <= cnt_n;
            buf0  <= buf0_n;
            buf1  <= buf1_n;
            beat  <= beat_n;
            valid <= (cnt_n != 2'd0);
            last  <= (cnt_n != 2'd0) && (beat_n == LAST_BEAT);
            done  <= acc & last;
        end
    end

    assign bus.fifo_rd_en = ld;
    assign bus.m_valid    = valid;
    assign bus.m_data     = buf0;
    assign bus.m_last     = last;
    assign bus.pkt_done   = done;
endmodule

// File: tb/tb_fifo_stream_out.sv
// Randomized and directed checks of fifo_stream_out (BURST=4 and BURST=1 side
// by side) against a queue-based model of the FIFO and the stream.
module tb_fifo_stream_out;
    localparam int B4 = 4;

    logic clk, reset_n;
    fifo_stream_out_if #(.W(8)) b4 ();
    fifo_stream_out_if #(.W(8)) b1 ();

    fifo_stream_out #(.W(8), .BURST(B4)) u4 (.clk(clk), .reset_n(reset_n), .bus(b4.master));
    fifo_stream_out #(.W(8), .BURST(1))  u1 (.clk(clk), .reset_n(reset_n), .bus(b1.master));

    always #5 clk = ~clk;

    logic [7:0] q_fifo[$];
    logic [7:0] q_out[$];
    logic [7:0] acc_log[$];
    bit         last_log[$];
    int         beat, ld_cnt, pd_cnt, max_occ;
    bit         pd4, pd1;
    int         vectors, errors;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit rdy);
        b4.m_ready      = rdy;
        b1.m_ready      = rdy;
        b4.fifo_empty   = (q_fifo.size() == 0);
        b1.fifo_empty   = (q_fifo.size() == 0);
        b4.fifo_rd_data = (q_fifo.size() != 0) ? q_fifo[0] : 8'h00;
        b1.fifo_rd_data = b4.fifo_rd_data;
    endtask

    task automatic check_outputs();
        bit v;
        v = (q_out.size() != 0);
        chk("m_valid", b4.m_valid, v);
        chk("m_valid_b1", b1.m_valid, v);
        if (v) begin
            chk("m_data", b4.m_data, q_out[0]);
            chk("m_data_b1", b1.m_data, q_out[0]);
        end
        chk("m_last", b4.m_last, v && (beat == B4 - 1));
        chk("m_last_b1", b1.m_last, v);
        chk("pkt_done", b4.pkt_done, pd4);
        chk("pkt_done_b1", b1.pkt_done, pd1);
    endtask

    // One clock cycle: optionally write a word upstream, apply m_ready, check
    // the pop strobe, then advance the model across the rising edge.
    task automatic step(bit rdy, bit push, logic [7:0] d);
        bit exp_ld, exp_acc;
        if (push) q_fifo.push_back(d);
        drive(rdy);
        #1;
        exp_ld  = reset_n && (q_fifo.size() != 0) && (q_out.size() < 2);
        exp_acc = (q_out.size() != 0) && rdy;
        chk("fifo_rd_en", b4.fifo_rd_en, exp_ld);
        chk("fifo_rd_en_b1", b1.fifo_rd_en, exp_ld);
        @(posedge clk);
        pd4 = exp_acc && (beat == B4 - 1);
        pd1 = exp_acc;
        if (exp_acc) begin
            acc_log.push_back(q_out[0]);
            last_log.push_back(beat == B4 - 1);
            void'(q_out.pop_front());
            beat = (beat + 1) % B4;
            if (pd4) pd_cnt++;
        end
        if (exp_ld) begin
            q_out.push_back(q_fifo.pop_front());
            ld_cnt++;
        end
        if (q_out.size() > max_occ) max_occ = q_out.size();
        @(negedge clk);
        check_outputs();
    endtask

    // Reset both the DUT and the upstream FIFO; optionally keep a word visible
    // so the pop strobe is shown to stay low while in reset.
    task automatic reset_pulse(bit hold_word);
        reset_n = 1'b0;
        q_fifo.delete();
        q_out.delete();
        beat = 0; pd4 = 0; pd1 = 0;
        if (hold_word) q_fifo.push_back(8'h55);
        drive(1'b1);
        #1;
        chk("rst_rd_en", b4.fifo_rd_en, 1'b0);
        chk("rst_m_data", b4.m_data, 8'h00);
        check_outputs();
        @(negedge clk);
        chk("rst_rd_en_hold", b4.fifo_rd_en, 1'b0);
        check_outputs();
        reset_n = 1'b1;
        acc_log.delete(); last_log.delete();
        ld_cnt = 0; pd_cnt = 0; max_occ = 0;
    endtask

    initial begin
        clk = 0; reset_n = 0; vectors = 0; errors = 0;
        beat = 0; pd4 = 0; pd1 = 0;
        drive(1'b0);
        @(negedge clk);

        // Reset with a non-empty FIFO, then the first pop right after release.
        reset_pulse(1'b1);
        step(1'b0, 1'b0, 8'h00);
        chk("first_pop", ld_cnt, 1);

        // Streaming 0x10..0x17 with m_ready held high.
        reset_pulse(1'b0);
        for (int i = 0; i < 8; i++) q_fifo.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00);
        chk("stream_pops", ld_cnt, 8);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
        chk("stream_count", acc_log.size(), 8);
        for (int i = 0; i < acc_log.size(); i++) begin
            chk("stream_order", acc_log[i], 8'h10 + 8'(i));
            chk("stream_last", last_log[i], (i == 3 || i == 7));
        end
        chk("stream_pkts", pd_cnt, 2);

        // Backpressure in cycles 2-4.
        reset_pulse(1'b0);
        for (int i = 0; i < 8; i++) q_fifo.push_back(8'h10 + 8'(i));
        for (int c = 0; c < 16; c++) step(!(c >= 2 && c <= 4), 1'b0, 8'h00);
        chk("bp_occ2", max_occ, 2);
        chk("bp_count", acc_log.size(), 8);
        for (int i = 0; i < acc_log.size(); i++) chk("bp_order", acc_log[i], 8'h10 + 8'(i));

        // Single word then empty.
        reset_pulse(1'b0);
        step(1'b1, 1'b1, 8'hA5);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h00);
        chk("empty_pops", ld_cnt, 1);
        chk("empty_count", acc_log.size(), 1);
        if (acc_log.size() == 1) begin
            chk("empty_data", acc_log[0], 8'hA5);
            chk("empty_last", last_log[0], 1'b0);
        end
        chk("empty_beat", beat, 1);

        // Reset after two beats of a packet, then a fresh packet.
        reset_pulse(1'b0);
        for (int i = 0; i < 4; i++) q_fifo.push_back(8'h20 + 8'(i));
        for (int c = 0; c < 10 && acc_log.size() < 2; c++) step(1'b1, 1'b0, 8'h00);
        chk("mid_accepts", acc_log.size(), 2);
        reset_pulse(1'b0);
        for (int i = 0; i < 4; i++) q_fifo.push_back(8'h30 + 8'(i));
        for (int c = 0; c < 12 && acc_log.size() < 4; c++) step(1'b1, 1'b0, 8'h00);
        chk("mid_count", acc_log.size(), 4);
        for (int i = 0; i < acc_log.size(); i++) begin
            chk("mid_data", acc_log[i], 8'h30 + 8'(i));
            chk("mid_last", last_log[i], i == 3);
        end

        // Random traffic with occasional resets.
        reset_pulse(1'b0);
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 199) == 0) reset_pulse(1'b0);
            else step($urandom_range(0, 3) != 0,
                      (q_fifo.size() < 6) && ($urandom_range(0, 2) != 0),
                      8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
